// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand forwarding, load-use stall and redirect flush control
// for the five-stage pipeline. A three-entry scoreboard (EX/MEM/WB) mirrors
// the destination register of each in-flight instruction.
// Optional feature macro: HAZARD_PERF_EN enables the stall/flush counters;
// when undefined the counters are absent and both outputs read 0.
module hazard_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [4:0]  id_rR1,
   input  logic [4:0]  id_rR2,
   input  logic        id_re1,
   input  logic        id_re2,
   input  logic [4:0]  id_wR,
   input  logic        id_rf_we,
   input  logic [1:0]  id_wd_sel,
   input  logic [31:0] ex_result,
   input  logic [31:0] mem_result,
   input  logic [31:0] wb_result,
   input  logic        ex_redirect,
   output logic        stall_pc,
   output logic        stall_if_id,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic        rD1_op,
   output logic        rD2_op,
   output logic [31:0] rD1_forward,
   output logic [31:0] rD2_forward,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);

   localparam int unsigned DW = 32;
   localparam int unsigned RW = 5;
   localparam logic [1:0]  WD_SEL_DRAM = 2'd1;

   typedef struct packed {
      logic          v;
      logic          we;
      logic [RW-1:0] wr;
      logic          ld;
   } tag_t;

   tag_t ex_tag, mem_tag, wb_tag;
   tag_t ex_tag_nxt;

   logic ex1_m, mem1_m, wb1_m;
   logic ex2_m, mem2_m, wb2_m;
   logic lu1, lu2, load_use;

   // An entry supplies register r only if it is a live writer of a non-zero index.
   function automatic logic tag_match(input tag_t t, input logic [RW-1:0] r);
      return t.v && t.we && (t.wr == r) && (r != '0);
   endfunction

   // Per-operand match vectors, gated by the operand read enables.
   always_comb begin
      ex1_m  = id_re1 && tag_match(ex_tag,  id_rR1);
      mem1_m = id_re1 && tag_match(mem_tag, id_rR1);
      wb1_m  = id_re1 && tag_match(wb_tag,  id_rR1);
      ex2_m  = id_re2 && tag_match(ex_tag,  id_rR2);
      mem2_m = id_re2 && tag_match(mem_tag, id_rR2);
      wb2_m  = id_re2 && tag_match(wb_tag,  id_rR2);
      lu1    = id_valid && ex1_m && ex_tag.ld;
      lu2    = id_valid && ex2_m && ex_tag.ld;
      load_use = lu1 || lu2;
   end

   // Stall/flush decision; a redirect overrides any load-use stall.
   always_comb begin
      stall_pc    = 1'b0;
      stall_if_id = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      if (ex_redirect) begin
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end else if (load_use) begin
         stall_pc    = 1'b1;
         stall_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end
   end

   // Operand 1 forward mux: EX > MEM > WB; a load in EX cannot forward yet.
   always_comb begin
      rD1_op      = 1'b0;
      rD1_forward = '0;
      if (ex1_m) begin
         if (!ex_tag.ld) begin
            rD1_op      = 1'b1;
            rD1_forward = ex_result;
         end
      end else if (mem1_m) begin
         rD1_op      = 1'b1;
         rD1_forward = mem_result;
      end else if (wb1_m) begin
         rD1_op      = 1'b1;
         rD1_forward = wb_result;
      end
   end

   // Operand 2 forward mux: EX > MEM > WB; a load in EX cannot forward yet.
   always_comb begin
      rD2_op      = 1'b0;
      rD2_forward = '0;
      if (ex2_m) begin
         if (!ex_tag.ld) begin
            rD2_op      = 1'b1;
            rD2_forward = ex_result;
         end
      end else if (mem2_m) begin
         rD2_op      = 1'b1;
         rD2_forward = mem_result;
      end else if (wb2_m) begin
         rD2_op      = 1'b1;
         rD2_forward = wb_result;
      end
   end

   // Next EX tag: the ID instruction, or a bubble when ID/EX is flushed.
   always_comb begin
      ex_tag_nxt = '0;
      if (!flush_id_ex) begin
         ex_tag_nxt.v  = id_valid;
         ex_tag_nxt.we = id_rf_we;
         ex_tag_nxt.wr = id_wR;
         ex_tag_nxt.ld = (id_wd_sel == WD_SEL_DRAM);
      end
   end

   // Scoreboard shift; MEM and WB entries are never flushed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_tag  <= '0;
         mem_tag <= '0;
         wb_tag  <= '0;
      end else begin
         ex_tag  <= ex_tag_nxt;
         mem_tag <= ex_tag;
         wb_tag  <= mem_tag;
      end
   end

`ifdef HAZARD_PERF_EN
   // Free-running wrap-around stall/flush event counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_pc)    stall_cnt <= stall_cnt + DW'(1);
         if (flush_if_id) flush_cnt <= flush_cnt + DW'(1);
      end
   end
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
